// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the pong game sequencer.
package pong_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned FCNT_W  = 7;
  localparam int unsigned HCNT_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_MISS  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Button/datapath inputs and game-status outputs of the pong sequencer.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               vsync;
  logic               start;
  logic               pause;
  logic               hit;
  logic               miss;
  logic               enabled;
  logic               ball_reset;
  logic [SPEED_W-1:0] pspeed;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;
  logic               game_over;
  logic [STATE_W-1:0] state;

  // Stimulus side: buttons, vsync and ball datapath events.
  modport master (
    output vsync, start, pause, hit, miss,
    input  enabled, ball_reset, pspeed, score, lives, game_over, state
  );

  // Sequencer side.
  modport slave (
    input  vsync, start, pause, hit, miss,
    output enabled, ball_reset, pspeed, score, lives, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a registered one-cycle edge pulse.
module sync_edge #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_pulse;

  // Synchronise, remember the previous level and register the selected edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_d;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_pulse <= FALL ? (r_prev & ~r_s2) : (r_s2 & ~r_prev);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/pause/miss/over control, score, lives, speed.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned MISS_FRAMES    = 90,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned SPEED_INIT     = 2,
  parameter int unsigned SPEED_MAX      = 8,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic            vclock,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);

  logic w_tick;
  logic w_start;
  logic w_pause;
  logic w_hit;
  logic w_miss;

  sync_edge #(.FALL(1'b1)) u_vsync (.clk(vclock), .rst_n(reset), .i_d(bus.vsync), .o_pulse(w_tick));
  sync_edge #(.FALL(1'b0)) u_start (.clk(vclock), .rst_n(reset), .i_d(bus.start), .o_pulse(w_start));
  sync_edge #(.FALL(1'b0)) u_pause (.clk(vclock), .rst_n(reset), .i_d(bus.pause), .o_pulse(w_pause));
  sync_edge #(.FALL(1'b0)) u_hit   (.clk(vclock), .rst_n(reset), .i_d(bus.hit),   .o_pulse(w_hit));
  sync_edge #(.FALL(1'b0)) u_miss  (.clk(vclock), .rst_n(reset), .i_d(bus.miss),  .o_pulse(w_miss));

  state_e             r_state;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [HCNT_W-1:0]  r_hcnt;
  logic [SCORE_W-1:0] r_score;
  logic [LIVES_W-1:0] r_lives;
  logic [SPEED_W-1:0] r_pspeed;
  logic               r_enabled;
  logic               r_ball_reset;
  logic               r_game_over;

  // Game FSM with counters; status outputs follow the state one cycle later.
  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_fcnt       <= '0;
      r_hcnt       <= '0;
      r_score      <= '0;
      r_lives      <= LIVES_W'(LIVES);
      r_pspeed     <= SPEED_W'(SPEED_INIT);
      r_enabled    <= 1'b0;
      r_ball_reset <= 1'b1;
      r_game_over  <= 1'b0;
    end else begin
      r_enabled    <= (r_state == ST_PLAY);
      r_ball_reset <= !((r_state == ST_PLAY) || (r_state == ST_PAUSE));
      r_game_over  <= (r_state == ST_OVER);

      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start) begin
            r_state  <= ST_SERVE;
            r_score  <= '0;
            r_lives  <= LIVES_W'(LIVES);
            r_pspeed <= SPEED_W'(SPEED_INIT);
            r_hcnt   <= '0;
            r_fcnt   <= '0;
          end
        end

        ST_SERVE: begin
          if (w_tick) begin
            if (r_fcnt == FCNT_W'(SERVE_FRAMES - 1)) begin
              r_fcnt  <= '0;
              r_state <= ST_PLAY;
            end else begin
              r_fcnt <= r_fcnt + FCNT_W'(1);
            end
          end
        end

        ST_PLAY: begin
          if (w_miss) begin
            // A miss swallows any coincident hit or pause.
            r_lives <= r_lives - LIVES_W'(1);
            r_fcnt  <= '0;
            r_state <= ST_MISS;
          end else begin
            if (w_hit) begin
              if (r_score != {SCORE_W{1'b1}}) begin
                r_score <= r_score + SCORE_W'(1);
              end
              if (r_hcnt == HCNT_W'(HITS_PER_LEVEL - 1)) begin
                r_hcnt <= '0;
                if (r_pspeed != SPEED_W'(SPEED_MAX)) begin
                  r_pspeed <= r_pspeed + SPEED_W'(1);
                end
              end else begin
                r_hcnt <= r_hcnt + HCNT_W'(1);
              end
            end
            if (w_pause) begin
              r_state <= ST_PAUSE;
            end
          end
        end

        ST_PAUSE: begin
          if (w_pause) begin
            r_state <= ST_PLAY;
          end
        end

        ST_MISS: begin
          if (w_tick) begin
            if (r_fcnt == FCNT_W'(MISS_FRAMES - 1)) begin
              r_fcnt  <= '0;
              r_state <= (r_lives == '0) ? ST_OVER : ST_SERVE;
            end else begin
              r_fcnt <= r_fcnt + FCNT_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.enabled    = r_enabled;
  assign bus.ball_reset = r_ball_reset;
  assign bus.pspeed     = r_pspeed;
  assign bus.score      = r_score;
  assign bus.lives      = r_lives;
  assign bus.game_over  = r_game_over;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scenario bench for pong_game_ctrl with a frame/hit-count reference model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int SERVE_F = 60;
  localparam int MISS_F  = 90;
  localparam int LIVES0  = 3;
  localparam int SP_INIT = 2;
  localparam int SP_MAX  = 8;
  localparam int HPL     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .SERVE_FRAMES(SERVE_F), .MISS_FRAMES(MISS_F), .LIVES(LIVES0),
    .SPEED_INIT(SP_INIT), .SPEED_MAX(SP_MAX), .HITS_PER_LEVEL(HPL)
  ) dut (
    .vclock(clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game phase, lives left, paddle hits this game.
  int m_st;
  int m_lives;
  int m_hits;

  logic [19:0] obs;
  assign obs = {bus.state, bus.enabled, bus.ball_reset, bus.game_over,
                bus.lives, bus.pspeed, bus.score};

  function automatic logic [19:0] pk(int st, int en, int br, int go, int lv, int sp, int sc);
    return {3'(st), 1'(en), 1'(br), 1'(go), 2'(lv), 4'(sp), 8'(sc)};
  endfunction

  function automatic int exp_speed(int h);
    int s;
    s = SP_INIT + h / HPL;
    return (s > SP_MAX) ? SP_MAX : s;
  endfunction

  function automatic int exp_score(int h);
    return (h > 255) ? 255 : h;
  endfunction

  function automatic logic [19:0] model_vec();
    int en;
    int br;
    en = (m_st == ST_PLAY) ? 1 : 0;
    br = (m_st == ST_PLAY || m_st == ST_PAUSE) ? 0 : 1;
    return pk(m_st, en, br, (m_st == ST_OVER) ? 1 : 0, m_lives,
              exp_speed(m_hits), exp_score(m_hits));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    bus.vsync = 1'b1;
    idle(4);
    bus.vsync = 1'b0;
    idle(6);
  endtask

  // 0=start 1=pause 2=hit 3=miss 4=hit+miss together; random level width.
  task automatic press(input int which);
    int w;
    w = $urandom_range(1, 5);
    bus.start = (which == 0);
    bus.pause = (which == 1);
    bus.hit   = (which == 2) || (which == 4);
    bus.miss  = (which == 3) || (which == 4);
    idle(w);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    idle(6);
  endtask

  // From SERVE: run SERVE_F frames and check the exact PLAY hand-over timing.
  task automatic do_serve(input string tag);
    for (int f = 1; f < SERVE_F; f++) begin
      frame();
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL %s_serve_frame%0d got %h want %h", tag, f, obs, model_vec());
      end
    end
    bus.vsync = 1'b1;
    idle(4);
    bus.vsync = 1'b0;
    idle(4);
    n_vec++;
    if (obs !== pk(ST_PLAY, 0, 1, 0, m_lives, exp_speed(m_hits), exp_score(m_hits))) begin
      n_err++;
      $display("FAIL %s_play_entry got %h want %h", tag, obs,
               pk(ST_PLAY, 0, 1, 0, m_lives, exp_speed(m_hits), exp_score(m_hits)));
    end
    idle(1);
    m_st = ST_PLAY;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL %s_play_enabled got %h want %h", tag, obs, model_vec());
    end
    idle(2);
  endtask

  task automatic test_reset();
    bus.vsync = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    rst_n = 1'b0;
    m_st = ST_IDLE;
    m_lives = LIVES0;
    m_hits = 0;
    idle(3);
    n_vec++;
    if (obs !== pk(ST_IDLE, 0, 1, 0, 3, 2, 0)) begin
      n_err++;
      $display("FAIL reset_values got %h want %h", obs, pk(ST_IDLE, 0, 1, 0, 3, 2, 0));
    end
    rst_n = 1'b1;
    idle(3);
    frame();
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL reset_idle_hold got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_serve();
    bus.start = 1'b1;
    idle(10);
    bus.start = 1'b0;
    idle(6);
    m_st = ST_SERVE;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL serve_entry got %h want %h", obs, model_vec());
    end
    press(0);
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL serve_start_ignored got %h want %h", obs, model_vec());
    end
    do_serve("first");
  endtask

  task automatic test_hits();
    int extra;
    for (int i = 1; i <= 9; i++) begin
      press(2);
      m_hits++;
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL hit%0d got %h want %h", i, obs, model_vec());
      end
    end
    extra = $urandom_range(3, 6);
    for (int i = 0; i < extra; i++) begin
      press(2);
      m_hits++;
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL hit_extra%0d got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_hit_miss();
    press(4);
    m_lives--;
    m_st = ST_MISS;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL hit_miss_together got %h want %h", obs, model_vec());
    end
    for (int f = 1; f < MISS_F; f++) frame();
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL miss_before_expiry got %h want %h", obs, model_vec());
    end
    frame();
    m_st = ST_SERVE;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL miss_to_serve got %h want %h", obs, model_vec());
    end
    do_serve("after_miss");
  endtask

  task automatic test_pause();
    press(1);
    m_st = ST_PAUSE;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL pause_enter got %h want %h", obs, model_vec());
    end
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0: press(3);
        1: press(2);
        2: press(0);
        default: frame();
      endcase
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL paused_ignore%0d got %h want %h", i, obs, model_vec());
      end
    end
    press(1);
    m_st = ST_PLAY;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL pause_resume got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_game_over();
    int k;
    while (m_lives > 0) begin
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        press(2);
        m_hits++;
      end
      press(3);
      m_lives--;
      m_st = ST_MISS;
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL go_miss_lives%0d got %h want %h", m_lives, obs, model_vec());
      end
      for (int f = 0; f < MISS_F; f++) frame();
      idle(1);
      m_st = (m_lives > 0) ? ST_SERVE : ST_OVER;
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL go_expiry_lives%0d got %h want %h", m_lives, obs, model_vec());
      end
      if (m_lives > 0) do_serve("go");
    end
    press(1);
    press(2);
    press(3);
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL over_hold got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_restart();
    press(0);
    m_st = ST_SERVE;
    m_lives = LIVES0;
    m_hits = 0;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL restart got %h want %h", obs, model_vec());
    end
    do_serve("restart");
  endtask

  task automatic test_async_reset();
    int k;
    k = $urandom_range(1, 6);
    for (int i = 0; i < k; i++) begin
      press(2);
      m_hits++;
    end
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL pre_reset_play got %h want %h", obs, model_vec());
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_st = ST_IDLE;
    m_lives = LIVES0;
    m_hits = 0;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL async_reset got %h want %h", obs, model_vec());
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++) begin
      case ($urandom_range(0, 3))
        0: press(1);
        1: press(2);
        2: press(3);
        default: frame();
      endcase
      n_vec++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL idle_after_reset%0d got %h want %h", i, obs, model_vec());
      end
    end
    press(0);
    m_st = ST_SERVE;
    n_vec++;
    if (obs !== model_vec()) begin
      n_err++;
      $display("FAIL start_after_reset got %h want %h", obs, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_hits();
    test_hit_miss();
    test_pause();
    test_game_over();
    test_restart();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
